// File: rtl/fnn_seq_pkg.sv
// Shared state encoding and default geometry for the FNN batch sequencer.
package fnn_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_WAIT,
        S_W_LOAD,
        S_IMG,
        S_FIN,
        S_RST
    } seq_state_t;

    localparam int WEIGHT_WIDTH_DEF  = 16;
    localparam int PART_NO_WIDTH_DEF = 7;
    localparam int INDATA_WIDTH_DEF  = 16;
    localparam int NO_OF_INPUTS_DEF  = 784;
    // 784*40+40 + 40*10+10 + 10*10+10 + 10*10+10
    localparam int NO_OF_WEIGHTS_DEF = 32030;
    localparam int WADDR_WIDTH_DEF   = 15;
    localparam int PADDR_WIDTH_DEF   = 17;
    localparam int IMG_WIDTH_DEF     = 8;

endpackage

// File: rtl/fnn_pix_prefetch.sv
// Two-entry pixel buffer in front of a 1-cycle-latency pixel RAM; tracks the
// in-flight read so the buffer never overflows while still sustaining 1 pixel/cycle.
module fnn_pix_prefetch #(
    parameter int INDATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    restart,
    input  logic                    issue_en,
    input  logic                    accept,
    input  logic [INDATA_WIDTH-1:0] p_data,
    output logic                    p_rd,
    output logic                    pix_vld,
    output logic [INDATA_WIDTH-1:0] pix_data
);

    logic [INDATA_WIDTH-1:0] buf_q [2];
    logic                    wr_ptr_q;
    logic                    rd_ptr_q;
    logic [1:0]              occ_q;
    logic                    pend_q;
    logic                    push;
    logic                    pop;
    logic [2:0]              used;
    logic [2:0]              limit;

    assign pix_vld  = (occ_q != 2'd0);
    assign pix_data = buf_q[rd_ptr_q];
    assign pop      = pix_vld & accept;
    assign push     = pend_q;

    // A pop this cycle frees a slot, so it is credited before deciding to issue.
    assign used  = {1'b0, occ_q} + {2'b00, pend_q};
    assign limit = 3'd2 + {2'b00, pop};
    assign p_rd  = issue_en && (used < limit);

    always_ff @(posedge clk) begin
        if (restart) begin
            for (int i = 0; i < 2; i++) buf_q[i] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
            pend_q   <= 1'b0;
        end else begin
            pend_q <= p_rd;
            if (push) begin
                buf_q[wr_ptr_q] <= p_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/fnn_batch_sequencer.sv
// Autonomous weight/pixel sequencer for control_FNN.
// Optional per-image cycle counter enabled by defining FNN_SEQ_PERF_EN.
module fnn_batch_sequencer
    import fnn_seq_pkg::*;
#(
    parameter int WEIGHT_WIDTH  = WEIGHT_WIDTH_DEF,
    parameter int PART_NO_WIDTH = PART_NO_WIDTH_DEF,
    parameter int INDATA_WIDTH  = INDATA_WIDTH_DEF,
    parameter int NO_OF_INPUTS  = NO_OF_INPUTS_DEF,
    parameter int NO_OF_WEIGHTS = NO_OF_WEIGHTS_DEF,
    parameter int WADDR_WIDTH   = WADDR_WIDTH_DEF,
    parameter int PADDR_WIDTH   = PADDR_WIDTH_DEF,
    parameter int IMG_WIDTH     = IMG_WIDTH_DEF
) (
    input  logic                                  clk,
    input  logic                                  restart,
    input  logic                                  go,
    input  logic                                  reload_w,
    input  logic [IMG_WIDTH-1:0]                  num_images,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  w_rd,
    output logic [WADDR_WIDTH-1:0]                w_addr,
    input  logic [PART_NO_WIDTH+WEIGHT_WIDTH-1:0] w_data,
    output logic                                  p_rd,
    output logic [PADDR_WIDTH-1:0]                p_addr,
    input  logic [INDATA_WIDTH-1:0]               p_data,
    output logic                                  fnn_load_weights,
    output logic                                  fnn_weight_valid,
    output logic [PART_NO_WIDTH+WEIGHT_WIDTH-1:0] fnn_weight_bus,
    input  logic                                  fnn_ready,
    input  logic                                  fnn_accept,
    output logic                                  fnn_start,
    output logic                                  fnn_ready_in,
    output logic                                  fnn_restart,
    output logic [INDATA_WIDTH-1:0]               fnn_input,
    input  logic                                  fnn_finish,
    input  logic [3:0]                            fnn_max,
    output logic                                  res_valid,
    output logic [3:0]                            res_max,
    output logic [IMG_WIDTH-1:0]                  res_index,
    output logic [31:0]                           perf_cycles
);

    localparam int PIX_CW = $clog2(NO_OF_INPUTS + 1);
    localparam logic [WADDR_WIDTH:0] W_END    = (WADDR_WIDTH+1)'(NO_OF_WEIGHTS);
    localparam logic [PIX_CW-1:0]    PIX_END  = PIX_CW'(NO_OF_INPUTS);
    localparam logic [PIX_CW-1:0]    PIX_LAST = PIX_CW'(NO_OF_INPUTS - 1);

    seq_state_t             state_q, state_d;
    logic [IMG_WIDTH-1:0]   num_q, img_q;
    logic [WADDR_WIDTH:0]   w_cnt_q;
    logic                   w_vld_p1;
    logic [PIX_CW-1:0]      pix_iss_q, pix_cnt_q;
    logic [PADDR_WIDTH-1:0] p_addr_q;
    logic                   res_valid_q, done_q, rst_pulse_q;
    logic [3:0]             res_max_q;
    logic [IMG_WIDTH-1:0]   res_index_q;
    logic                   issue_en, acc_en, pix_vld, xfer, pix_last, w_last_beat, last_img, fin_hit;
    logic [INDATA_WIDTH-1:0] pix_data;

    assign w_last_beat = w_vld_p1 && (w_cnt_q == W_END);
    assign last_img    = (img_q == num_q - IMG_WIDTH'(1));
    assign fin_hit     = (state_q == S_FIN) && fnn_finish;
    assign xfer        = fnn_ready_in && fnn_accept;
    assign pix_last    = xfer && (pix_cnt_q == PIX_LAST);

    always_comb begin
        state_d          = state_q;
        busy             = (state_q != S_IDLE);
        w_rd             = 1'b0;
        fnn_load_weights = 1'b0;
        fnn_start        = 1'b0;
        issue_en         = 1'b0;
        acc_en           = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go && (num_images != '0)) state_d = reload_w ? S_W_WAIT : S_IMG;
            end
            S_W_WAIT: begin
                if (fnn_ready) state_d = S_W_LOAD;
            end
            S_W_LOAD: begin
                fnn_load_weights = 1'b1;
                w_rd             = (w_cnt_q != W_END);
                if (w_last_beat) state_d = S_IMG;
            end
            S_IMG: begin
                fnn_start = 1'b1;
                issue_en  = (pix_iss_q != PIX_END);
                acc_en    = 1'b1;
                if (pix_last) state_d = S_FIN;
            end
            S_FIN: begin
                fnn_start = 1'b1;
                if (fnn_finish) state_d = last_img ? S_IDLE : S_RST;
            end
            S_RST: begin
                state_d = S_IMG;
            end
            default: state_d = S_IDLE;
        endcase
    end

    fnn_pix_prefetch #(
        .INDATA_WIDTH(INDATA_WIDTH)
    ) u_prefetch (
        .clk      (clk),
        .restart  (restart),
        .issue_en (issue_en),
        .accept   (acc_en & fnn_accept),
        .p_data   (p_data),
        .p_rd     (p_rd),
        .pix_vld  (pix_vld),
        .pix_data (pix_data)
    );

    assign w_addr           = w_cnt_q[WADDR_WIDTH-1:0];
    assign p_addr           = p_addr_q;
    assign fnn_weight_valid = w_vld_p1;
    assign fnn_weight_bus   = w_vld_p1 ? w_data : '0;
    assign fnn_ready_in     = acc_en && pix_vld;
    assign fnn_input        = pix_data;
    assign fnn_restart      = restart | rst_pulse_q;
    assign done             = done_q;
    assign res_valid        = res_valid_q;
    assign res_max          = res_max_q;
    assign res_index        = res_index_q;

    always_ff @(posedge clk) begin
        if (restart) begin
            state_q     <= S_IDLE;
            num_q       <= '0;
            img_q       <= '0;
            w_cnt_q     <= '0;
            w_vld_p1    <= 1'b0;
            pix_iss_q   <= '0;
            pix_cnt_q   <= '0;
            p_addr_q    <= '0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
            rst_pulse_q <= 1'b0;
            res_max_q   <= '0;
            res_index_q <= '0;
        end else begin
            state_q     <= state_d;
            done_q      <= ((state_q == S_IDLE) && go && (num_images == '0)) || (fin_hit && last_img);
            res_valid_q <= fin_hit;
            rst_pulse_q <= fin_hit && !last_img;
            w_vld_p1    <= w_rd;
            if ((state_q == S_IDLE) && go) begin
                num_q    <= num_images;
                img_q    <= '0;
                p_addr_q <= '0;
            end else if (p_rd) begin
                p_addr_q <= p_addr_q + PADDR_WIDTH'(1);
            end
            if (w_rd) w_cnt_q <= w_cnt_q + (WADDR_WIDTH+1)'(1);
            else if (state_q != S_W_LOAD) w_cnt_q <= '0;
            // Per-image pixel bookkeeping restarts once the last pixel is handed over.
            if (pix_last) pix_iss_q <= '0;
            else if (p_rd) pix_iss_q <= pix_iss_q + PIX_CW'(1);
            if (xfer) pix_cnt_q <= pix_last ? '0 : pix_cnt_q + PIX_CW'(1);
            if (fin_hit) begin
                res_max_q   <= fnn_max;
                res_index_q <= img_q;
                if (!last_img) img_q <= img_q + IMG_WIDTH'(1);
            end
        end
    end

`ifdef FNN_SEQ_PERF_EN
    logic [31:0] cyc_p0, perf_p1;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Counts IMG entry through the fnn_finish cycle inclusive.
    always_ff @(posedge clk) begin
        if (restart) begin
            cyc_p0  <= '0;
            perf_p1 <= '0;
        end else begin
            if ((state_q != S_IMG) && (state_d == S_IMG)) cyc_p0 <= '0;
            else if ((state_q == S_IMG) || (state_q == S_FIN && !fnn_finish)) cyc_p0 <= sat_inc(cyc_p0);
            if (fin_hit) perf_p1 <= sat_inc(cyc_p0);
        end
    end

    assign perf_cycles = perf_p1;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_fnn_batch_sequencer.sv
// Directed bench for fnn_batch_sequencer with small geometry, ROM/RAM models and an FNN model.
module tb_fnn_batch_sequencer;

    localparam int WW = 23;

    logic        clk = 1'b0;
    logic        restart = 1'b1, go = 1'b0, reload_w = 1'b0;
    logic [7:0]  num_images = '0;
    logic        busy, done, w_rd, p_rd;
    logic [14:0] w_addr;
    logic [WW-1:0] w_data = '0;
    logic [16:0] p_addr;
    logic [15:0] p_data = '0;
    logic        fnn_load_weights, fnn_weight_valid;
    logic [WW-1:0] fnn_weight_bus;
    logic        fnn_ready = 1'b1, fnn_accept = 1'b1;
    logic        fnn_start, fnn_ready_in, fnn_restart;
    logic [15:0] fnn_input;
    logic        fnn_finish = 1'b0;
    logic [3:0]  fnn_max = '0;
    logic        res_valid;
    logic [3:0]  res_max;
    logic [7:0]  res_index;
    logic [31:0] perf_cycles;

    int n_cmp = 0, n_fail = 0;

    fnn_batch_sequencer #(
        .NO_OF_INPUTS (4),
        .NO_OF_WEIGHTS(6)
    ) dut (
        .clk(clk), .restart(restart), .go(go), .reload_w(reload_w), .num_images(num_images),
        .busy(busy), .done(done), .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data),
        .p_rd(p_rd), .p_addr(p_addr), .p_data(p_data),
        .fnn_load_weights(fnn_load_weights), .fnn_weight_valid(fnn_weight_valid),
        .fnn_weight_bus(fnn_weight_bus), .fnn_ready(fnn_ready), .fnn_accept(fnn_accept),
        .fnn_start(fnn_start), .fnn_ready_in(fnn_ready_in), .fnn_restart(fnn_restart),
        .fnn_input(fnn_input), .fnn_finish(fnn_finish), .fnn_max(fnn_max),
        .res_valid(res_valid), .res_max(res_max), .res_index(res_index), .perf_cycles(perf_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [WW-1:0] wrom(input int a);
        logic [6:0]  pn;
        logic [15:0] wv;
        pn = 7'(a + 1);
        wv = 16'(4096 + a * 17);
        return {pn, wv};
    endfunction

    function automatic logic [15:0] prom(input int a);
        return 16'(a * 3 + 1);
    endfunction

    always @(posedge clk) begin
        if (w_rd) w_data <= wrom(int'(w_addr));
        if (p_rd) p_data <= prom(int'(p_addr));
    end

    // Observation logs and FNN behavioural model
    int  w_log[$], beat_cyc[$], p_log[$], xfer_log[$], rmax_log[$], ridx_log[$], perf_log[$];
    logic [WW-1:0] beat_log[$];
    int  cyc = 0, done_cnt = 0, rstp_cnt = 0, unstable = 0;
    int  m_cnt = 0, m_sum = 0, m_pend = 0, img_cyc = 0, perf_exp = 0;
    bit  hold_prev = 1'b0, prev_start = 1'b0;
    logic [15:0] prev_in = '0;

    always @(negedge clk) begin
        cyc++;
        if (w_rd) w_log.push_back(int'(w_addr));
        if (fnn_weight_valid) begin
            beat_log.push_back(fnn_weight_bus);
            beat_cyc.push_back(cyc);
        end
        if (p_rd) p_log.push_back(int'(p_addr));
        if (res_valid) begin
            rmax_log.push_back(int'(res_max));
            ridx_log.push_back(int'(res_index));
            perf_log.push_back(int'(perf_cycles));
        end
        if (done) done_cnt++;
        if (fnn_restart && !restart) rstp_cnt++;
        if (hold_prev && (!fnn_ready_in || fnn_input !== prev_in)) unstable++;
        hold_prev = fnn_ready_in && !fnn_accept;
        prev_in   = fnn_input;
        if (fnn_start) img_cyc = prev_start ? img_cyc + 1 : 1;
        prev_start = fnn_start;
        fnn_finish = 1'b0;
        if (fnn_restart) begin
            m_cnt = 0; m_sum = 0; m_pend = 0;
        end else begin
            if (fnn_start && fnn_ready_in && fnn_accept) begin
                xfer_log.push_back(int'(fnn_input));
                m_sum += int'(fnn_input);
                m_cnt++;
                if (m_cnt == 4) m_pend = 2;
            end
            if (m_pend > 0) begin
                m_pend--;
                if (m_pend == 0) begin
                    fnn_finish = 1'b1;
                    fnn_max    = 4'(m_sum % 10);
                    perf_exp   = img_cyc;
                    m_cnt = 0; m_sum = 0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input bit rl, input int n);
        reload_w   = rl;
        num_images = 8'(n);
        go         = 1'b1;
        tick();
        go         = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input bit toggle);
        int  n0;
        bit  ok;
        n0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (toggle) fnn_accept = ~fnn_accept;
            if (done_cnt != n0) begin
                ok = 1'b1;
                break;
            end
        end
        fnn_accept = 1'b1;
        check(tag, 64'(ok), 64'd1);
    endtask

    task automatic check_perf(input string tag);
`ifdef FNN_SEQ_PERF_EN
        check(tag, 64'(perf_log[perf_log.size()-1]), 64'(perf_exp));
`else
        check(tag, 64'(perf_cycles), 64'd0);
`endif
    endtask

    initial begin
        int wb, bb, pb, rb, xb, rs, dc, rd0;
        int exp_max[3];
        exp_max[0] = 2; exp_max[1] = 0; exp_max[2] = 8;

        // Reset state
        tick(); tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_wrd", 64'(w_rd), 64'd0);
        check("rst_prd", 64'(p_rd), 64'd0);
        check("rst_start", 64'(fnn_start), 64'd0);
        check("rst_fnn_restart", 64'(fnn_restart), 64'd1);
        check("rst_wvalid", 64'(fnn_weight_valid), 64'd0);
        restart = 1'b0;
        #1;
        check("rst_release", 64'(fnn_restart), 64'd0);

        // One image with weight load
        wb = w_log.size(); bb = beat_log.size(); pb = p_log.size(); rb = rmax_log.size();
        start(1'b1, 1);
        wait_done("t1_done", 200, 1'b0);
        check("t1_wrd_cnt", 64'(w_log.size() - wb), 64'd6);
        for (int i = 0; i < 6; i++) begin
            check("t1_waddr", 64'(w_log[wb+i]), 64'(i));
            check("t1_beat", 64'(beat_log[bb+i]), 64'(wrom(i)));
        end
        check("t1_beat_span", 64'(beat_cyc[bb+5] - beat_cyc[bb]), 64'd5);
        check("t1_prd_cnt", 64'(p_log.size() - pb), 64'd4);
        for (int i = 0; i < 4; i++) check("t1_paddr", 64'(p_log[pb+i]), 64'(i));
        check("t1_res_cnt", 64'(rmax_log.size() - rb), 64'd1);
        check("t1_res_max", 64'(rmax_log[rb]), 64'd2);
        check("t1_res_idx", 64'(ridx_log[rb]), 64'd0);
        check_perf("t1_perf");
        tick();
        check("t1_idle", 64'(busy), 64'd0);

        // Three images reusing weights
        wb = w_log.size(); pb = p_log.size(); rb = rmax_log.size(); rs = rstp_cnt;
        start(1'b0, 3);
        wait_done("t2_done", 400, 1'b0);
        check("t2_no_wrd", 64'(w_log.size() - wb), 64'd0);
        check("t2_prd_cnt", 64'(p_log.size() - pb), 64'd12);
        for (int i = 0; i < 12; i++) check("t2_paddr", 64'(p_log[pb+i]), 64'(i));
        check("t2_res_cnt", 64'(rmax_log.size() - rb), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check("t2_res_max", 64'(rmax_log[rb+i]), 64'(exp_max[i]));
            check("t2_res_idx", 64'(ridx_log[rb+i]), 64'(i));
        end
        check("t2_restarts", 64'(rstp_cnt - rs), 64'd2);

        // Back-pressure: accept toggles every cycle
        xb = xfer_log.size(); rb = rmax_log.size(); unstable = 0;
        start(1'b0, 1);
        wait_done("t3_done", 300, 1'b1);
        check("t3_xfer_cnt", 64'(xfer_log.size() - xb), 64'd4);
        for (int i = 0; i < 4; i++) check("t3_pixel", 64'(xfer_log[xb+i]), 64'(prom(i)));
        check("t3_stable", 64'(unstable), 64'd0);
        check("t3_res_max", 64'(rmax_log[rb]), 64'd2);

        // FNN not ready: weight load must wait
        wb = w_log.size(); rb = rmax_log.size();
        fnn_ready = 1'b0;
        start(1'b1, 1);
        repeat (20) tick();
        check("t4_no_wrd", 64'(w_log.size() - wb), 64'd0);
        check("t4_busy", 64'(busy), 64'd1);
        fnn_ready = 1'b1;
        wait_done("t4_done", 200, 1'b0);
        check("t4_wrd_cnt", 64'(w_log.size() - wb), 64'd6);
        check("t4_res_max", 64'(rmax_log[rb]), 64'd2);

        // Restart in the middle of the weight load
        bb = beat_log.size(); rb = rmax_log.size(); dc = done_cnt;
        start(1'b1, 1);
        begin
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 50; i++) begin
                tick();
                if (beat_log.size() - bb >= 3) begin
                    hit = 1'b1;
                    break;
                end
            end
            check("t5_beat3", 64'(hit), 64'd1);
        end
        restart = 1'b1;
        tick();
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_wrd", 64'(w_rd), 64'd0);
        check("t5_load", 64'(fnn_load_weights), 64'd0);
        check("t5_wvalid", 64'(fnn_weight_valid), 64'd0);
        check("t5_wbus", 64'(fnn_weight_bus), 64'd0);
        check("t5_start", 64'(fnn_start), 64'd0);
        restart = 1'b0;
        tick();
        check("t5_no_res", 64'(rmax_log.size() - rb), 64'd0);
        check("t5_no_done", 64'(done_cnt - dc), 64'd0);
        wb = w_log.size();
        start(1'b1, 1);
        wait_done("t5_redo", 200, 1'b0);
        check("t5_wrd_cnt", 64'(w_log.size() - wb), 64'd6);
        check("t5_waddr0", 64'(w_log[wb]), 64'd0);
        check("t5_res_max", 64'(rmax_log[rb]), 64'd2);

        // Empty batch
        tick();
        rd0 = w_log.size() + p_log.size();
        start(1'b1, 0);
        check("t6_done", 64'(done), 64'd1);
        check("t6_busy", 64'(busy), 64'd0);
        tick();
        check("t6_done_pulse", 64'(done), 64'd0);
        repeat (3) tick();
        check("t6_no_reads", 64'(w_log.size() + p_log.size() - rd0), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
